// File: rtl/reg_fifo.sv
// rtl/reg_fifo.sv - first-word-fall-through register FIFO with valid/ready handshake on both sides
module reg_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      count
);

    localparam logic [AW:0]   L_FULL    = DEPTH[AW:0];
    localparam logic [AW:0]   L_CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] L_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Handshake flags are gated by reset so nothing leaks while the FIFO is being cleared.
    assign in_ready  = (r_count != L_FULL) && !reset;
    assign out_valid = (r_count != '0) && !reset;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Storage is deliberately not reset; stale words are hidden by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_fifo.sv
// tb/tb_reg_fifo.sv - vector table plus randomized queue-model checks for reg_fifo
module tb_reg_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        iv;
    logic        ir;
    logic [15:0] dout;
    logic        ov;
    logic        ordy;
    logic [2:0]  cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        e_ov;
        logic [15:0] e_od;
        logic [2:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] q[$];

    reg_fifo #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(rst),
        .in_data(din), .in_valid(iv), .in_ready(ir),
        .out_data(dout), .out_valid(ov), .out_ready(ordy),
        .count(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [15:0] d, input logic o,
                       input logic eov, input logic [15:0] eod, input logic [2:0] ec, input logic eir);
        vec_t t;
        t.rst = r; t.iv = v; t.din = d; t.ordy = o;
        t.e_ov = eov; t.e_od = eod; t.e_cnt = ec; t.e_ir = eir;
        tbl.push_back(t);
    endtask

    task automatic check_all(input string tag, input logic eov, input logic [15:0] eod,
                             input logic [2:0] ec, input logic eir);
        chk({tag, ".out_valid"}, {31'b0, ov}, {31'b0, eov});
        chk({tag, ".out_data"}, {16'b0, dout}, {16'b0, eod});
        chk({tag, ".count"}, {29'b0, cnt}, {29'b0, ec});
        chk({tag, ".in_ready"}, {31'b0, ir}, {31'b0, eir});
    endtask

    // One model-checked cycle: FIFO semantics from a plain queue
    task automatic mcycle(input string tag, input logic r, input logic v, input logic [15:0] d,
                          input logic o, output logic popped, output logic [15:0] pval);
        logic do_push;
        logic do_pop;
        rst = r; iv = v; din = d; ordy = o;
        do_push = v && !r && (q.size() < 4);
        do_pop  = o && !r && (q.size() > 0);
        popped  = do_pop;
        pval    = do_pop ? q[0] : 16'h0;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        check_all(tag, !r && q.size() > 0, (!r && q.size() > 0) ? q[0] : 16'h0,
                  3'(q.size()), !r && q.size() < 4);
    endtask

    initial begin
        logic        p;
        logic [15:0] pv;
        int          next;
        int          rcv;

        rst = 1'b1; iv = 1'b0; din = '0; ordy = 1'b0;

        add(1, 1, 16'hAAAA, 1, 0, 16'h0000, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
        add(0, 1, 16'h1234, 0, 1, 16'h1234, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'h0001, 0, 1, 16'h0001, 1, 1);
        add(0, 1, 16'h0002, 0, 1, 16'h0001, 2, 1);
        add(0, 1, 16'h0003, 0, 1, 16'h0001, 3, 1);
        add(0, 1, 16'h0004, 0, 1, 16'h0001, 4, 0);
        add(0, 1, 16'h0005, 0, 1, 16'h0001, 4, 0);
        add(0, 1, 16'h0006, 1, 1, 16'h0002, 3, 1);
        add(0, 0, 16'h0000, 1, 1, 16'h0003, 2, 1);
        add(0, 0, 16'h0000, 1, 1, 16'h0004, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hA001, 0, 1, 16'hA001, 1, 1);
        add(0, 1, 16'hA002, 0, 1, 16'hA001, 2, 1);
        add(0, 1, 16'hB001, 1, 1, 16'hA002, 2, 1);
        add(0, 0, 16'h0000, 1, 1, 16'hB001, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hC001, 0, 1, 16'hC001, 1, 1);
        add(0, 1, 16'hC002, 1, 1, 16'hC002, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hD001, 0, 1, 16'hD001, 1, 1);
        add(0, 1, 16'hD002, 0, 1, 16'hD001, 2, 1);
        add(0, 1, 16'hD003, 0, 1, 16'hD001, 3, 1);
        add(1, 1, 16'hDEAD, 1, 0, 16'h0000, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
        add(0, 1, 16'hBEEF, 0, 1, 16'hBEEF, 1, 1);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; iv = tbl[i].iv; din = tbl[i].din; ordy = tbl[i].ordy;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_od, tbl[i].e_cnt, tbl[i].e_ir);
        end

        // Data stability: head must hold while pushes land behind it
        q.delete();
        mcycle("stab_rst", 1, 0, 16'h0, 0, p, pv);
        mcycle("stab0", 0, 1, 16'h5A5A, 0, p, pv);
        for (int i = 0; i < 4; i++) begin
            mcycle("stab", 0, 1, 16'(16'h6000 + i), 0, p, pv);
            chk("stab_head", {16'b0, dout}, 32'h5A5A);
        end

        // Wrap stress: 20 sequential words with random handshakes
        mcycle("wrap_rst", 1, 0, 16'h0, 0, p, pv);
        next = 0;
        rcv  = 0;
        for (int c = 0; c < 400 && rcv < 20; c++) begin
            logic v;
            v = (next < 20) && ($urandom_range(0, 3) != 0);
            mcycle("wrap", 0, v, 16'(next), 1'($urandom_range(0, 1)), p, pv);
            if (v && q.size() > 0 && q[q.size()-1] == 16'(next)) next++;
            if (p) begin
                chk("wrap_order", {16'b0, pv}, rcv);
                rcv++;
            end
        end
        chk("wrap_done", rcv, 20);

        // Long random run with occasional resets
        for (int c = 0; c < 300; c++) begin
            mcycle("rand", $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                   16'($urandom), 1'($urandom_range(0, 1)), p, pv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
